// File: rtl/pulse_meter.sv
// pulse_meter: measures the width, in clock cycles, of each high pulse on
// `in` and hands every measured width to a byte consumer over a 4-phase
// dav_/rfd handshake.  A small FIFO buffers widths measured while the
// consumer is busy.
//
// Optional feature macro: PULSE_METER_OVF_EN
//   defined   -> `ovf` port present; sticky flag set when a width is dropped
//   undefined -> no `ovf` port; dropped widths are silently discarded
//
// Handshake (producer side): data is valid while dav_==0 and never changes
// while dav_==0.  The producer only lowers dav_ when rfd==1.  It raises dav_
// once the consumer drops rfd.  It then waits for rfd to return to 1 before
// it may offer the next value.
//
// dbg_state exposes the output FSM state (0=IDLE, 1=PRESENT, 2=RELEASE).
module pulse_meter #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         in,
  output logic         dav_,
  input  logic         rfd,
  output logic [W-1:0] data,
`ifdef PULSE_METER_OVF_EN
  output logic         ovf,
`endif
  output logic [1:0]   dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Input register and width counter
  // ---------------------------------------------------------------------
  logic         in_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic         push;

  // Count while the registered input is high (saturating).  The first low
  // sample after a non-zero count ends the pulse and requests a push.
  always_comb begin
    cnt_d = cnt_q;
    push  = 1'b0;
    if (in_q) begin
      if (cnt_q != {W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_q != '0) begin
      push  = 1'b1;
      cnt_d = '0;
    end
  end

  // Input sampling and counter state.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      in_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      in_q  <= in;
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_COUNT);

  // A push into a full FIFO is accepted only if a pop frees the slot in the
  // same cycle; otherwise the width is dropped and the FIFO is unchanged.
  assign push_ok = push && (!fifo_full || pop);

  // Pointer and occupancy update for simultaneous push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clock) begin
    if (reset_ && push_ok) begin
      mem_q[wr_ptr_q] <= cnt_q;
    end
  end

  // ---------------------------------------------------------------------
  // Output handshake FSM
  // ---------------------------------------------------------------------
  state_t       state_q, state_d;
  logic [W-1:0] data_q, data_d;

  // Next state and load decision; data only changes on IDLE->PRESENT.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && rfd) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (!rfd) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (rfd) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and output data register.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign dav_      = (state_q != PRESENT);
  assign data      = data_q;
  assign dbg_state = state_q;

`ifdef PULSE_METER_OVF_EN
  logic ovf_q;
  logic drop;

  assign drop = push && fifo_full && !pop;

  // Sticky overflow: set on any dropped width, cleared only by reset.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pulse_meter.sv
// Directed testbench for pulse_meter (W=8, DEPTH=4).
module tb_pulse_meter;

  logic       clock;
  logic       reset_;
  logic       in;
  logic       dav_;
  logic       rfd;
  logic [7:0] data;
  logic [1:0] dbg_state;
`ifdef PULSE_METER_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int fails  = 0;

  pulse_meter #(.W(8), .DEPTH(4)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .in        (in),
    .dav_      (dav_),
    .rfd       (rfd),
    .data      (data),
`ifdef PULSE_METER_OVF_EN
    .ovf       (ovf),
`endif
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    reset_ = 1'b0;
    in     = 1'b0;
    rfd    = 1'b0;
  end

  // Driver tasks: inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int n);
    in = 1'b1;
    repeat (n) tick();
    in = 1'b0;
  endtask

  task automatic gap(input int n);
    in = 1'b0;
    repeat (n) tick();
  endtask

  // Consumer side: wait (bounded) for dav_ low, check value and hold,
  // then complete the 4-phase handshake.
  task automatic recv(input logic [7:0] exp, input string name);
    int n = 0;
    rfd = 1'b1;
    while (dav_ !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (dav_ !== 1'b0) begin
      fails++;
      $display("FAIL %s_timeout: dav_=%b expected 0 within 100 cycles", name, dav_);
    end else begin
      checks++;
      if (data !== exp) begin
        fails++;
        $display("FAIL %s_data: got %0d expected %0d", name, data, exp);
      end
      tick();
      checks++;
      if (dav_ !== 1'b0 || data !== exp) begin
        fails++;
        $display("FAIL %s_hold: dav_=%b data=%0d expected dav_=0 data=%0d", name, dav_, data, exp);
      end
      rfd = 1'b0;
      tick();
      checks++;
      if (dav_ !== 1'b1) begin
        fails++;
        $display("FAIL %s_release: dav_=%b expected 1", name, dav_);
      end
      rfd = 1'b1;
      tick();
    end
  endtask

  task automatic expect_quiet(input int n, input string name);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (dav_ !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      fails++;
      $display("FAIL %s: dav_ low on %0d cycles expected 0", name, lows);
    end
  endtask

  // Test 1: reset with in high; width measured from release.
  task automatic test_reset();
    reset_ = 1'b0;
    in     = 1'b1;
    rfd    = 1'b0;
    tick();
    tick();
    checks++;
    if (dav_ !== 1'b1) begin fails++; $display("FAIL reset_dav: got %b expected 1", dav_); end
    checks++;
    if (data !== 8'd0) begin fails++; $display("FAIL reset_data: got %0d expected 0", data); end
    checks++;
    if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
`ifdef PULSE_METER_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    reset_ = 1'b1;
    rfd    = 1'b1;
    expect_quiet(4, "reset_no_push_while_high");
    in = 1'b0;
    recv(8'd4, "reset_release_width");
  endtask

  // Test 2: single 6-cycle pulse, latency and full handshake.
  task automatic test_single();
    rfd = 1'b1;
    pulse(6);
    tick();
    tick();
    checks++;
    if (dav_ !== 1'b1) begin fails++; $display("FAIL single_early: dav_=%b expected 1 at push edge", dav_); end
    tick();
    checks++;
    if (dav_ !== 1'b0) begin fails++; $display("FAIL single_latency: dav_=%b expected 0", dav_); end
    checks++;
    if (data !== 8'd6) begin fails++; $display("FAIL single_data: got %0d expected 6", data); end
    rfd = 1'b0;
    tick();
    checks++;
    if (dav_ !== 1'b1 || dbg_state !== 2'd2) begin
      fails++;
      $display("FAIL single_release: dav_=%b state=%0d expected dav_=1 state=2", dav_, dbg_state);
    end
    rfd = 1'b1;
    tick();
    checks++;
    if (dav_ !== 1'b1 || dbg_state !== 2'd0) begin
      fails++;
      $display("FAIL single_idle: dav_=%b state=%0d expected dav_=1 state=0", dav_, dbg_state);
    end
    expect_quiet(5, "single_quiet");
  endtask

  // Test 3: results buffered while consumer busy, order preserved; 1-cycle gaps.
  task automatic test_back_to_back();
    rfd = 1'b0;
    pulse(12);
    gap(1);
    pulse(6);
    gap(1);
    pulse(12);
    gap(4);
    checks++;
    if (dav_ !== 1'b1) begin fails++; $display("FAIL b2b_wait: dav_=%b expected 1 while rfd=0", dav_); end
    recv(8'd12, "b2b_first");
    recv(8'd6,  "b2b_second");
    recv(8'd12, "b2b_third");
    expect_quiet(10, "b2b_drained");
  endtask

  // Test 4: very long pulse saturates.
  task automatic test_saturate();
    rfd = 1'b1;
    pulse(300);
    recv(8'd255, "saturate");
  endtask

  // Test 5: five pulses into a 4-deep FIFO; fifth is lost.
  task automatic test_overflow();
    rfd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse(6);
      gap(2);
    end
    gap(4);
`ifdef PULSE_METER_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b expected 1", ovf); end
`endif
    for (int i = 0; i < 4; i++) recv(8'd6, "overflow_entry");
    expect_quiet(10, "overflow_fifth_lost");
`ifdef PULSE_METER_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
`endif
  endtask

  // Test 6: reset while presenting with two entries still queued.
  task automatic test_reset_mid();
    int n = 0;
    rfd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse(6);
      gap(1);
    end
    gap(4);
    rfd = 1'b1;
    while (dav_ !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (dav_ !== 1'b0) begin fails++; $display("FAIL midreset_setup: dav_=%b expected 0", dav_); end
    reset_ = 1'b0;
    tick();
    checks++;
    if (dav_ !== 1'b1) begin fails++; $display("FAIL midreset_dav: got %b expected 1", dav_); end
    checks++;
    if (data !== 8'd0) begin fails++; $display("FAIL midreset_data: got %0d expected 0", data); end
`ifdef PULSE_METER_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin fails++; $display("FAIL midreset_ovf: got %b expected 0", ovf); end
`endif
    reset_ = 1'b1;
    expect_quiet(20, "midreset_fifo_empty");
    pulse(5);
    recv(8'd5, "midreset_new_pulse");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturate();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
